// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and the receive-capture FSM state encoding.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic {
        CAP_IDLE = 1'b0,
        CAP_ACK  = 1'b1
    } cap_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic synchronous FIFO with show-ahead read port, level/flags and a dominant flush.
module uart_sync_fifo #(
    parameter  int DEPTH = 16,
    parameter  int W     = 8,
    localparam int PW    = $clog2(DEPTH),
    localparam int LW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic          flush,
    output logic [W-1:0]  rd_data,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign pop_ok  = rd_en && !empty;
    // A full FIFO still accepts a write when the same cycle frees the head slot.
    assign push_ok = wr_en && (!full || rd_en);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush && !rst) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side buffer: drains bytes from the UART receiver into a FIFO, with overrun and level irq.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_valid,
    input  logic [UART_DATA_W-1:0] rx_data,
    output logic                   rx_read,
    input  logic                   pop,
    output logic [UART_DATA_W-1:0] pop_data,
    output logic                   empty,
    output logic                   full,
    output logic [LVL_W-1:0]       level,
    input  logic [LVL_W-1:0]       thresh,
    input  logic                   irq_en,
    output logic                   irq,
    output logic                   overrun,
    input  logic                   clr_overrun,
    input  logic                   flush
);

    // Handshake: the receiver raises rx_valid with rx_data stable and holds both until it
    // samples rx_read=1 on a clock edge; rx_read is a single-cycle pulse per captured byte,
    // issued whether or not the byte fit, so the receiver never stalls.
    cap_state_e             state;
    logic                   capture;
    logic [LVL_W-1:0]       thr_eff;

    assign capture = (state == CAP_IDLE) && rx_valid;
    assign thr_eff = (thresh == '0) ? LVL_W'(1) : thresh;

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .W     (UART_DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (capture),
        .wr_data (rx_data),
        .rd_en   (pop),
        .flush   (flush),
        .rd_data (pop_data),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CAP_IDLE;
            rx_read <= 1'b0;
        end else begin
            case (state)
                CAP_IDLE: begin
                    if (rx_valid) begin
                        rx_read <= 1'b1;
                        state   <= CAP_ACK;
                    end
                end
                CAP_ACK: begin
                    rx_read <= 1'b0;
                    state   <= CAP_IDLE;
                end
                default: begin
                    rx_read <= 1'b0;
                    state   <= CAP_IDLE;
                end
            endcase
        end
    end

    // A dropped byte sets overrun even if software clears it in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
            irq     <= 1'b0;
        end else begin
            if (capture && full && !pop && !flush) overrun <= 1'b1;
            else if (clr_overrun)                  overrun <= 1'b0;
            irq <= irq_en && (level >= thr_eff);
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed plus randomized bench for uart_rx_fifo with a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             rx_valid = 1'b0;
    logic [7:0]       rx_data = '0;
    logic             rx_read;
    logic             pop = 1'b0;
    logic [7:0]       pop_data;
    logic             empty;
    logic             full;
    logic [LVL_W-1:0] level;
    logic [LVL_W-1:0] thresh = '0;
    logic             irq_en = 1'b0;
    logic             irq;
    logic             overrun;
    logic             clr_overrun = 1'b0;
    logic             flush = 1'b0;

    int total = 0;
    int bad   = 0;
    int reads = 0;

    logic [7:0] q[$];
    bit         m_ovr = 1'b0;
    bit         m_irq = 1'b0;

    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_read     (rx_read),
        .pop         (pop),
        .pop_data    (pop_data),
        .empty       (empty),
        .full        (full),
        .level       (level),
        .thresh      (thresh),
        .irq_en      (irq_en),
        .irq         (irq),
        .overrun     (overrun),
        .clr_overrun (clr_overrun),
        .flush       (flush)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rx_read === 1'b1) reads <= reads + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        m_ovr = 1'b0;
        m_irq = 1'b0;
    endfunction

    // One clock edge of the reference: irq reflects the level held before this edge.
    function automatic void model_edge(bit v, logic [7:0] b, bit p, bit f, bit clr);
        int  t;
        bit  do_pop;
        bit  do_push;
        t = (thresh == 0) ? 1 : int'(thresh);
        m_irq = irq_en && (q.size() >= t);
        if (f) begin
            q.delete();
            if (clr) m_ovr = 1'b0;
        end else begin
            do_pop  = p && (q.size() != 0);
            do_push = v && ((q.size() < DEPTH) || p);
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(b);
            if (v && !do_push) m_ovr = 1'b1;
            else if (clr)      m_ovr = 1'b0;
        end
    endfunction

    task automatic check_state(input string tag);
        chk({tag, ".rx_read"}, rx_read, 0);
        chk({tag, ".level"}, level, q.size());
        chk({tag, ".empty"}, empty, q.size() == 0);
        chk({tag, ".full"}, full, q.size() == DEPTH);
        chk({tag, ".overrun"}, overrun, m_ovr);
        chk({tag, ".irq"}, irq, m_irq);
        if (q.size() != 0) chk({tag, ".pop_data"}, pop_data, q[0]);
    endtask

    // Called at a negedge; presents one byte (held through ACK) and/or pop/flush/clear for
    // the capture cycle, then lets the ACK cycle complete. Returns at a negedge.
    task automatic step(input string tag, input bit v, input logic [7:0] b, input bit p,
                        input bit f, input bit clr);
        int r0;
        r0 = reads;
        rx_valid = v; rx_data = b; pop = p; flush = f; clr_overrun = clr;
        @(posedge clk); model_edge(v, b, p, f, clr);
        @(negedge clk);
        pop = 1'b0; flush = 1'b0; clr_overrun = 1'b0;
        chk({tag, ".ack"}, rx_read, v);
        chk({tag, ".irq_mid"}, irq, m_irq);
        @(posedge clk); model_edge(0, 8'h00, 0, 0, 0);
        @(negedge clk);
        rx_valid = 1'b0;
        chk({tag, ".reads"}, reads - r0, v);
        check_state(tag);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        model_reset();
        @(negedge clk);
        check_state("reset");
        rst = 1'b0;

        // single byte
        step("t1", 1, 8'hA5, 0, 0, 0);
        chk("t1.data", pop_data, 8'hA5);
        step("t1_pop", 0, 8'h00, 1, 0, 0);

        // fill, overflow, drain
        for (int i = 0; i < DEPTH; i++) step("t2_push", 1, 8'(i), 0, 0, 0);
        step("t2_ovf", 1, 8'hFF, 0, 0, 0);
        chk("t2.full", full, 1);
        chk("t2.ovr", overrun, 1);
        step("t2_ovf_clr", 1, 8'hFE, 0, 0, 1);
        chk("t2.set_wins", overrun, 1);
        for (int i = 0; i < DEPTH; i++) begin
            chk("t2.order", pop_data, 8'(i));
            step("t2_pop", 0, 8'h00, 1, 0, 0);
        end
        step("t2_clr", 0, 8'h00, 0, 0, 1);

        // full + push + pop in the same cycle
        for (int i = 0; i < DEPTH; i++) step("t3_push", 1, 8'(8'h20 + i), 0, 0, 0);
        step("t3_both", 1, 8'h55, 1, 0, 0);
        chk("t3.level", level, DEPTH);
        chk("t3.ovr", overrun, 0);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) chk("t3.last", pop_data, 8'h55);
            step("t3_pop", 0, 8'h00, 1, 0, 0);
        end

        // threshold interrupt
        thresh = LVL_W'(4); irq_en = 1'b1;
        for (int i = 0; i < 3; i++) step("t4_push", 1, 8'(8'h40 + i), 0, 0, 0);
        chk("t4.irq_below", irq, 0);
        step("t4_push4", 1, 8'h43, 0, 0, 0);
        chk("t4.irq_at", irq, 1);
        step("t4_pop", 0, 8'h00, 1, 0, 0);
        chk("t4.irq_drop", irq, 0);
        step("t4_pop", 0, 8'h00, 1, 0, 0);
        step("t4_pop", 0, 8'h00, 1, 0, 0);
        thresh = '0;
        step("t4_thr0", 0, 8'h00, 0, 0, 0);
        chk("t4.irq_thr0", irq, 1);
        step("t4_pop", 0, 8'h00, 1, 0, 0);
        irq_en = 1'b0;

        // flush against a simultaneous push
        for (int i = 0; i < 5; i++) step("t5_push", 1, 8'(8'h60 + i), 0, 0, 0);
        step("t5_flush", 1, 8'h77, 1, 1, 0);
        chk("t5.level", level, 0);
        chk("t5.empty", empty, 1);
        step("t5_pop_empty", 0, 8'h00, 1, 0, 0);
        chk("t5.no_underflow", level, 0);

        // randomized traffic across several wraps
        for (int i = 0; i < 160; i++) begin
            if ((i % 40) == 0) begin
                thresh = LVL_W'($urandom_range(0, DEPTH));
                irq_en = 1'($urandom_range(0, 1));
            end
            step("t6_rand", $urandom_range(0, 9) < 7, 8'($urandom),
                 $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0,
                 $urandom_range(0, 9) == 0);
        end

        // reset in the middle of ACK, then a byte held across reset
        rx_valid = 1'b1; rx_data = 8'h99;
        @(posedge clk); model_edge(1, 8'h99, 0, 0, 0);
        @(negedge clk);
        chk("t6.ack_pre_rst", rx_read, 1);
        rst = 1'b1; rx_data = 8'h3C;
        @(posedge clk); model_reset();
        @(negedge clk);
        check_state("t6_rst");
        rst = 1'b0;
        @(posedge clk); model_edge(1, 8'h3C, 0, 0, 0);
        @(negedge clk);
        chk("t6.ack_post_rst", rx_read, 1);
        @(posedge clk); model_edge(0, 8'h00, 0, 0, 0);
        @(negedge clk);
        rx_valid = 1'b0;
        check_state("t6_post");
        chk("t6.held_byte", pop_data, 8'h3C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
